data_memory_bank: RTL and testbench
===================================

Name: data_memory_bank

Overview:
Parametrised successor to the MIPS16 data memory. Single-port word memory with a valid/ready request interface, byte-lane write enables, and a configurable-latency registered read pipeline. Misaligned and out-of-range accesses return an error response instead of halting simulation. A post-reset init FSM zero-fills the array, so no simulation-only initial block is needed. Sits between the MEM stage and the data RAM.

Parameters:
MEM_DEPTH, 256, number of words; power of two, at least 2.
DATA_WIDTH, 16, word width in bits; multiple of 8, at most 64.
READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
BYTES, DATA_WIDTH/8, derived: byte lanes per word.
ADDR_LSB, $clog2(BYTES), derived: byte-offset bits.
ADDR_WIDTH, $clog2(MEM_DEPTH), derived: word-index bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  DATA_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  write data.
req_be  in  BYTES  byte-lane write enables; ignored on reads.
resp_valid  out  1  one-cycle pulse; response for one accepted request.
resp_rdata  out  DATA_WIDTH  read data; '0 on writes and on errors.
resp_err  out  1  accepted request was misaligned or out of range.
init_done  out  1  zero-fill complete.

Behaviour:
- Reset values (asynchronous): req_ready=0, resp_valid=0, resp_rdata='0, resp_err=0, init_done=0, FSM=S_INIT, init counter=0, read pipeline valid bits cleared. Array contents are not reset.
- FSM states:
  - S_INIT: write '0 to word[cnt] each cycle. Increment cnt. When cnt==MEM_DEPTH-1 is written, go to S_READY. Takes exactly MEM_DEPTH cycles after reset release.
  - S_READY: init_done=1, req_ready=1 permanently. No further transitions except through rst.
- Reset asserted mid-init or mid-operation: FSM returns to S_INIT, cnt=0, in-flight responses are dropped (never emitted).
- Accept: a request is accepted when req_valid && req_ready. No response backpressure; at most one request per cycle; full throughput.
- Address check:
  - err = (req_addr[ADDR_LSB-1:0] != 0) || (req_addr[DATA_WIDTH-1:ADDR_LSB+ADDR_WIDTH] != 0). Each term is omitted when its range is empty.
  - Word index = req_addr[ADDR_LSB +: ADDR_WIDTH].
- Write: if !err, on the acceptance edge word[idx] byte b takes req_wdata byte b for every b with req_be[b]=1. Other bytes are unchanged. req_be=0 is legal and leaves the word unchanged.
- Read: array read registered at acceptance, then delayed READ_LATENCY-1 further stages.
- Response: every accepted request yields exactly one response, exactly READ_LATENCY cycles after acceptance, in order.
  - Read, no error: resp_rdata = word contents.
  - Write: resp_rdata='0, resp_err=0 (write acknowledge).
  - Any error: resp_rdata='0, resp_err=1, no array update.
- Write then read, same address, back-to-back cycles: the read returns the new data.
- Requests presented while req_ready=0 are ignored; no response.
- resp_rdata and resp_err are '0 whenever resp_valid=0.

Optional Feature:
DMEM_PARITY_EN
- With the macro defined:
  - Each word stores one even-parity bit per byte lane, written alongside the data; the init FSM writes 0 parity.
  - A read whose stored parity mismatches the data sets resp_err=1 and still returns the raw data on resp_rdata.
  - Adds a test-only input port inj_par_err (1 bit); when high during a write, parity of byte 0 is stored inverted.
- Without the macro: no parity storage, no inj_par_err port, resp_err reflects address errors only.

Decomposition:
- Package dmem_pkg holds:
  - typedef dmem_state_e {S_INIT, S_READY};
  - typedef dmem_resp_t packed struct {valid, err, rdata} for the pipeline stages;
  - localparam MAX_READ_LATENCY=4;
  - function be_merge(old, new, be).
- One natural sub-module: dmem_resp_pipe, a parametrised READ_LATENCY-1 stage shift of dmem_resp_t with asynchronous clear.

Test Plan:
- Reset release: init_done rises and req_ready=1 exactly 256 cycles later (defaults). Reading address 0x00FE returns 0x0000, err=0, one cycle after acceptance.
- Byte-lane write: write addr 0x0010, data 0xBEEF, be=2'b11. Then write data 0x1234, be=2'b01. Read 0x0010 returns 0xBE34.
- Errors:
  - Read addr 0x0011 gives resp_err=1, rdata=0.
  - Write addr 0x0200 gives err=1; a following read of word 0 (addr 0x0000) is unchanged.
- Throughput at READ_LATENCY=3: eight back-to-back reads yield eight consecutive resp_valid pulses, starting 3 cycles after the first accept, in order.
- Reset mid-stream: assert rst while 2 reads are in flight. No responses appear, init restarts, and init_done=0 for 256 cycles.
- Parity (DMEM_PARITY_EN): write 0x00A5 with inj_par_err=1; reading it back returns 0x00A5 with resp_err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory bank: FSM state encoding,
// the response record carried through the read pipeline, and a byte-merge helper.
package dmem_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_DATA_WIDTH   = 64;
    localparam int MAX_BYTES        = MAX_DATA_WIDTH / 8;

    typedef enum logic {
        S_INIT,
        S_READY
    } dmem_state_e;

    // rdata is sized for the widest supported word; narrower builds use the low bits.
    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [MAX_DATA_WIDTH-1:0] rdata;
    } dmem_resp_t;

    // Replace the bytes of old_word selected by be with the same bytes of new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Extra delay stages for memory responses; STAGES=0 is a plain pass-through.
// Reset clears every stage so in-flight responses are dropped.
module dmem_resp_pipe
    import dmem_pkg::*;
#(
    parameter int STAGES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  dmem_resp_t in_resp,
    output dmem_resp_t out_resp
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_resp = in_resp;
        end else begin : g_pipe
            dmem_resp_t stage_reg [STAGES];

            // Shift register of response records, cleared asynchronously.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= in_resp;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign out_resp = stage_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/data_memory_bank.sv
// Single-port word data memory with valid/ready requests, byte-lane writes,
// address error responses, post-reset zero fill and a configurable read latency.
// Optional macro DMEM_PARITY_EN adds per-byte even parity and the inj_par_err port.
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter  int MEM_DEPTH    = 256,
    parameter  int DATA_WIDTH   = 16,
    parameter  int READ_LATENCY = 1,
    localparam int BYTES        = DATA_WIDTH / 8,
    localparam int ADDR_LSB     = $clog2(BYTES),
    localparam int ADDR_WIDTH   = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DMEM_PARITY_EN
    input  logic                  inj_par_err,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BYTES-1:0]      req_be,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  init_done
);

    dmem_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rdata_reg;

    logic                    accept;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    addr_err;
    logic [ADDR_WIDTH-1:0]   req_idx;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_idx;
    logic [BYTES-1:0]        mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    s0_valid_reg, s0_err_reg, s0_read_reg;
    dmem_resp_t              s0_resp, out_resp;
    logic                    rdata_unused;

    assign req_ready = (state_reg == S_READY);
    assign init_done = (state_reg == S_READY);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[ADDR_LSB +: ADDR_WIDTH];

    // Address check terms exist only when their bit ranges are non-empty.
    generate
        if (ADDR_LSB > 0) begin : g_misalign
            assign misaligned = |req_addr[ADDR_LSB-1:0];
        end else begin : g_no_misalign
            assign misaligned = 1'b0;
        end
        if (ADDR_LSB + ADDR_WIDTH < DATA_WIDTH) begin : g_range
            assign out_of_range = |req_addr[DATA_WIDTH-1:ADDR_LSB+ADDR_WIDTH];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign addr_err = misaligned || out_of_range;

    // FSM state and zero-fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: walk every word once, then stay ready until reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                    state_next = S_READY;
                end
            end
            S_READY: ;
            default: state_next = S_INIT;
        endcase
    end

    // Write port mux: the zero-fill owns the port during init.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_be    = req_be;
        mem_wdata = req_wdata;
        if (state_reg == S_INIT) begin
            mem_we    = 1'b1;
            mem_idx   = cnt_reg;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept && req_write && !addr_err) begin
            mem_we    = 1'b1;
        end
    end

`ifdef DMEM_PARITY_EN
    logic [BYTES-1:0] par_mem [MEM_DEPTH];
    logic [BYTES-1:0] par_wdata;
    logic [BYTES-1:0] par_rdata_reg;
    logic [BYTES-1:0] par_calc;

    // Even parity per lane; lane 0 can be corrupted on purpose for testing.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_par_lane
        assign par_wdata[gi] = (^mem_wdata[gi*8 +: 8]) ^
                               ((gi == 0) && inj_par_err && req_ready);
        assign par_calc[gi]  = ^mem_rdata_reg[gi*8 +: 8];
    end
`endif

    // Array write with byte lanes and registered read on read acceptance.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
`ifdef DMEM_PARITY_EN
                    par_mem[mem_idx][b] <= par_wdata[b];
`endif
                end
            end
        end
        if (accept && !req_write) begin
            mem_rdata_reg <= mem[req_idx];
`ifdef DMEM_PARITY_EN
            par_rdata_reg <= par_mem[req_idx];
`endif
        end
    end

    // First response stage: request kind and address error captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= 1'b0;
            s0_read_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= accept;
            s0_err_reg   <= accept && addr_err;
            s0_read_reg  <= accept && !req_write;
        end
    end

    // Build the response record; data only for good reads.
    always_comb begin
        s0_resp       = '0;
        s0_resp.valid = s0_valid_reg;
        s0_resp.err   = s0_err_reg;
        if (s0_valid_reg && s0_read_reg && !s0_err_reg) begin
            s0_resp.rdata[DATA_WIDTH-1:0] = mem_rdata_reg;
`ifdef DMEM_PARITY_EN
            s0_resp.err = (par_calc != par_rdata_reg);
`endif
        end
    end

    dmem_resp_pipe #(
        .STAGES (READ_LATENCY - 1)
    ) u_resp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_resp  (s0_resp),
        .out_resp (out_resp)
    );

    assign resp_valid   = out_resp.valid;
    assign resp_err     = out_resp.valid && out_resp.err;
    assign resp_rdata   = out_resp.valid ? out_resp.rdata[DATA_WIDTH-1:0] : '0;
    // Bits above DATA_WIDTH in the record are always zero.
    assign rdata_unused = ^out_resp.rdata;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank: one instance at read latency 1 and one
// at latency 3 share the same request stimulus.
module tb_data_memory_bank;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
`ifdef DMEM_PARITY_EN
    logic        inj_par_err;
`endif

    logic        r1_ready, r1_valid, r1_err, r1_done;
    logic [15:0] r1_rdata;
    logic        r3_ready, r3_valid, r3_err, r3_done;
    logic [15:0] r3_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_bank #(.MEM_DEPTH(256), .DATA_WIDTH(16), .READ_LATENCY(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
`ifdef DMEM_PARITY_EN
        .inj_par_err(inj_par_err),
`endif
        .req_valid  (req_valid),
        .req_ready  (r1_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (r1_valid),
        .resp_rdata (r1_rdata),
        .resp_err   (r1_err),
        .init_done  (r1_done)
    );

    data_memory_bank #(.MEM_DEPTH(256), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
`ifdef DMEM_PARITY_EN
        .inj_par_err(inj_par_err),
`endif
        .req_valid  (req_valid),
        .req_ready  (r3_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (r3_valid),
        .resp_rdata (r3_rdata),
        .resp_err   (r3_err),
        .init_done  (r3_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on the latency-1 instance, response checked right after acceptance.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input logic [15:0] exp_d, input logic exp_e,
                        input string tag);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        $display("txn %s: wr=%0b addr=%h wdata=%h be=%b -> valid=%0b rdata=%h err=%0b",
                 tag, wr, addr, wd, be, r1_valid, r1_rdata, r1_err);
        chk({tag, "_valid"}, 64'(r1_valid), 64'd1);
        chk({tag, "_rdata"}, 64'(r1_rdata), 64'(exp_d));
        chk({tag, "_err"},   64'(r1_err),   64'(exp_e));
    endtask

    logic [15:0] tp_addr [8];
    logic [15:0] tp_data [8];
    logic        tp_err  [8];

    initial begin
        int  cyc;
        bit  seen;
        bit  stray;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
`ifdef DMEM_PARITY_EN
        inj_par_err = 1'b0;
`endif
        tick();
        tick();
        tick();
        $display("txn reset: ready=%0b done=%0b valid=%0b", r1_ready, r1_done, r1_valid);
        chk("rst_ready",  64'(r1_ready), 64'd0);
        chk("rst_done",   64'(r1_done),  64'd0);
        chk("rst_valid",  64'(r1_valid), 64'd0);
        chk("rst_rdata",  64'(r1_rdata), 64'd0);
        chk("rst_err",    64'(r1_err),   64'd0);
        chk("rst_done3",  64'(r3_done),  64'd0);

        // Zero fill takes exactly 256 edges after reset release.
        rst  = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 300 && !seen) begin
            tick();
            cyc++;
            if (r1_done) seen = 1'b1;
        end
        $display("txn init: cycles=%0d", cyc);
        chk("init_cycles", 64'(cyc), 64'd256);
        chk("init_ready",  64'(r1_ready), 64'd1);
        chk("init_done3",  64'(r3_done),  64'd1);

        xact(1'b0, 16'h00FE, 16'h0000, 2'b00, 16'h0000, 1'b0, "rd_fe");
        xact(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0, "wr_beef");
        xact(1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000, 1'b0, "wr_lo");
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0, "rd_be34");
        xact(1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000, 1'b0, "wr_be0");
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0, "rd_be0");
        xact(1'b0, 16'h0011, 16'h0000, 2'b00, 16'h0000, 1'b1, "rd_misal");
        xact(1'b1, 16'h0000, 16'h5A5A, 2'b11, 16'h0000, 1'b0, "wr_w0");
        xact(1'b1, 16'h0200, 16'hFFFF, 2'b11, 16'h0000, 1'b1, "wr_oor");
        xact(1'b0, 16'h0000, 16'h0000, 2'b00, 16'h5A5A, 1'b0, "rd_w0");
        xact(1'b1, 16'h0020, 16'hCAFE, 2'b11, 16'h0000, 1'b0, "wr_cafe");
        xact(1'b0, 16'h0020, 16'h0000, 2'b00, 16'hCAFE, 1'b0, "rd_cafe");

        tick();
        chk("idle_valid", 64'(r1_valid), 64'd0);
        chk("idle_rdata", 64'(r1_rdata), 64'd0);
        chk("idle_err",   64'(r1_err),   64'd0);

`ifdef DMEM_PARITY_EN
        inj_par_err = 1'b1;
        xact(1'b1, 16'h0030, 16'h00A5, 2'b11, 16'h0000, 1'b0, "par_wr");
        inj_par_err = 1'b0;
        xact(1'b0, 16'h0030, 16'h0000, 2'b00, 16'h00A5, 1'b1, "par_rd");
`endif

        // Let the latency-3 instance drain before streaming.
        tick();
        tick();
        tick();
        tick();

        tp_addr[0] = 16'h0000; tp_data[0] = 16'h5A5A; tp_err[0] = 1'b0;
        tp_addr[1] = 16'h0010; tp_data[1] = 16'hBE34; tp_err[1] = 1'b0;
        tp_addr[2] = 16'h0020; tp_data[2] = 16'hCAFE; tp_err[2] = 1'b0;
        tp_addr[3] = 16'h00FE; tp_data[3] = 16'h0000; tp_err[3] = 1'b0;
        tp_addr[4] = 16'h0011; tp_data[4] = 16'h0000; tp_err[4] = 1'b1;
        tp_addr[5] = 16'h0000; tp_data[5] = 16'h5A5A; tp_err[5] = 1'b0;
        tp_addr[6] = 16'h0020; tp_data[6] = 16'hCAFE; tp_err[6] = 1'b0;
        tp_addr[7] = 16'h0010; tp_data[7] = 16'hBE34; tp_err[7] = 1'b0;

        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = tp_addr[c];
            end else begin
                req_valid = 1'b0;
            end
            tick();
            $display("txn stream c=%0d: valid=%0b rdata=%h err=%0b", c, r3_valid, r3_rdata, r3_err);
            if (c >= 2 && c < 10) begin
                chk($sformatf("tp%0d_valid", c - 2), 64'(r3_valid), 64'd1);
                chk($sformatf("tp%0d_rdata", c - 2), 64'(r3_rdata), 64'(tp_data[c-2]));
                chk($sformatf("tp%0d_err",   c - 2), 64'(r3_err),   64'(tp_err[c-2]));
            end else begin
                chk($sformatf("tp_c%0d_idle", c), 64'(r3_valid), 64'd0);
            end
        end

        // Reset with two reads in flight on the latency-3 instance.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid3", 64'(r3_valid), 64'd0);
        chk("mid_rst_done",   64'(r3_done),  64'd0);
        tick();
        rst   = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        stray = 1'b0;
        while (cyc < 300 && !seen) begin
            tick();
            cyc++;
            if (r1_valid || r3_valid) stray = 1'b1;
            if (r3_done) seen = 1'b1;
        end
        req_valid = 1'b0;
        $display("txn reinit: cycles=%0d stray=%0b", cyc, stray);
        chk("reinit_cycles", 64'(cyc),   64'd256);
        chk("reinit_stray",  64'(stray), 64'd0);
        tick();
        chk("reinit_idle", 64'(r1_valid), 64'd0);
        xact(1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 1'b0, "rd_refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
